fp_ieee_to_flopoco_enc: RTL and testbench
=========================================

Name: fp_ieee_to_flopoco_enc

Overview:
- Streaming encoder: packed IEEE-style float (sign, biased exponent, fraction) in, FloPoCo internal format out (2-bit exception field, sign, exponent, fraction).
- Produces the exception encoding that FPSub-based comparators and arithmetic cores decode downstream.
- Sits at the ingress of the ray/AABB datapath, between host-side operand loading and the FPSub/compare units.
- 2-stage valid/ready pipeline with full backpressure.

Parameters:
- WE, 11, exponent width; bias 2^(WE-1)-1, identical on both sides.
- WF, 17, fraction width.
- Derived local constants: IN_W = 1+WE+WF (29); OUT_W = 3+WE+WF (31).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  encoder can accept a word this cycle.
- in_data  input  IN_W  {sign, exp[WE-1:0], frac[WF-1:0]}.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_W  {exn[1:0], sign, exp, frac}.
- (FP_ENC_STATS_EN only) stat_flush  output  16  subnormals flushed; stat_nan  output  16  NaNs seen; stat_clr  input  1  synchronous clear.

Behaviour:
- Classification, applied in stage 1:
  - exp == 0 → exn = 00 (zero). exp and frac are forced to 0, sign is kept. Subnormals flush to signed zero.
  - exp == all-ones, frac == 0 → exn = 10 (inf). exp and frac forced to 0, sign kept.
  - exp == all-ones, frac != 0 → exn = 11 (NaN). exp and frac forced to 0, sign kept.
  - Otherwise → exn = 01 (normal). exp and frac copied unchanged, no rebias.
- Pipeline: stage 1 register (s1_valid, s1_data), then stage 2 output register (out_valid, out_data).
  - Transfer happens on valid && ready at the clk edge.
  - Latency is 2 cycles from input handshake to out_valid when out_ready is held at 1.
  - Throughput is 1 word/cycle.
- Stage advance:
  - Stage 2 loads when (!out_valid || out_ready).
  - Stage 1 loads when (!s1_valid || stage 2 loads).
  - in_ready = !s1_valid || stage2_load. This is combinational from out_ready; a registered ready is not required.
- Backpressure: while out_ready = 0, out_valid and out_data hold stable. At most 2 words are buffered; in_ready then drops to 0. No word is lost or duplicated.
- Simultaneous accept and emit in the same cycle is legal whenever both stages move.
- Reset (rst = 0, asynchronous):
  - out_valid = 0, s1_valid = 0, out_data = 0, s1_data = 0.
  - in_ready reads 1 in the first cycle after release.
  - Reset mid-stream discards in-flight words; no partial word is emitted afterward.
- in_data is sampled only on handshake. X on in_data while in_valid = 0 must not propagate.

Optional Feature:
- Macro FP_ENC_STATS_EN.
- Defined:
  - Two 16-bit saturating counters, incremented at stage-1 load: stat_flush (exp == 0 && frac != 0) and stat_nan (NaN class).
  - Both saturate at 0xFFFF.
  - Reset to 0; stat_clr = 1 clears both on the next edge, and clear has priority over increment.
- Undefined: the counters, stat_* ports and all associated logic are absent; datapath behaviour is identical.

Decomposition:
- Shared package fp_flopoco_pkg: exception codes EXN_ZERO = 2'b00, EXN_NORMAL = 2'b01, EXN_INF = 2'b10, EXN_NAN = 2'b11; default WE/WF; bias constant.
- Comparators and FPSub wrappers import the same package.
- One natural sub-module, fp_enc_classify: purely combinational, in_data → {exn, sign, exp, frac}, instantiated in stage 1.
- Pipeline/handshake logic lives in the top module.

Test Plan:
- Normal: in_data 0x07FE0000 (1.0), out_ready = 1 → out_data 0x27FE0000 exactly 2 cycles after the handshake.
- Specials:
  - 0x1FFE0000 (−inf) → 0x50000000.
  - 0x0FFE0001 (NaN) → 0x60000000.
  - 0x10000000 (−0) → 0x10000000.
  - 0x00000005 (subnormal) → 0x00000000; with FP_ENC_STATS_EN, stat_flush increments to 1.
- Backpressure: stream 5 words with out_ready = 0 → in_ready = 0 after 2 accepted; out_data stable; release out_ready → all 5 emitted in order, one per cycle.
- Random valid/ready toggling, 10k words → output sequence equals the reference-model encoding of the input sequence; no drops or duplicates.
- Assert rst = 0 with 2 words in flight → out_valid = 0 immediately (asynchronous); after release, no stale word appears and the first new word has latency 2.
- FP_ENC_STATS_EN: 70000 NaNs → stat_nan = 0xFFFF (saturated); pulse stat_clr → both counters read 0 next cycle.

Source files
------------

// File: rtl/fp_flopoco_pkg.sv
// Shared FloPoco format definitions: exception codes, default widths and bias.
// Imported by the ingress encoder, comparators and FPSub wrappers.
package fp_flopoco_pkg;

  localparam int unsigned FP_WE = 11;
  localparam int unsigned FP_WF = 17;

  typedef enum logic [1:0] {
    EXN_ZERO   = 2'b00,
    EXN_NORMAL = 2'b01,
    EXN_INF    = 2'b10,
    EXN_NAN    = 2'b11
  } exn_e;

  // Bias is identical on the IEEE and FloPoco sides, so no rebias is needed.
  function automatic int unsigned fp_bias(input int unsigned we);
    return (32'd1 << (we - 32'd1)) - 32'd1;
  endfunction

  localparam int unsigned FP_BIAS = fp_bias(FP_WE);

endpackage

// File: rtl/fp_ieee_to_flopoco_enc_if.sv
// Valid/ready stream bundle; master drives valid/data, slave drives ready.
interface fp_ieee_to_flopoco_enc_if #(
  parameter int unsigned DW = 29
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fp_enc_classify.sv
// Combinational IEEE -> FloPoco classification: {sign,exp,frac} to {exn,sign,exp,frac}.
module fp_enc_classify
  import fp_flopoco_pkg::*;
#(
  parameter  int unsigned WE    = FP_WE,
  parameter  int unsigned WF    = FP_WF,
  localparam int unsigned IN_W  = 1 + WE + WF,
  localparam int unsigned OUT_W = 3 + WE + WF
) (
  input  logic [IN_W-1:0]  in_data_i,
  output logic [OUT_W-1:0] enc_c_o
);

  localparam int unsigned PW = WE + WF;

  logic          sign;
  logic [WE-1:0] exp_f;
  logic [WF-1:0] frac_f;

  always_comb begin
    {sign, exp_f, frac_f} = in_data_i;
    enc_c_o = {EXN_NORMAL, in_data_i};
    // Subnormals flush to signed zero; specials carry only sign and class.
    if (exp_f == '0) begin
      enc_c_o = {EXN_ZERO, sign, {PW{1'b0}}};
    end else if (exp_f == '1) begin
      if (frac_f == '0) enc_c_o = {EXN_INF, sign, {PW{1'b0}}};
      else              enc_c_o = {EXN_NAN, sign, {PW{1'b0}}};
    end
  end

endmodule

// File: rtl/fp_ieee_to_flopoco_enc.sv
// Two-stage valid/ready IEEE -> FloPoco ingress encoder with full backpressure.
// Optional saturating flush/NaN statistics counters under `FP_ENC_STATS_EN.
module fp_ieee_to_flopoco_enc
  import fp_flopoco_pkg::*;
#(
  parameter  int unsigned WE    = FP_WE,
  parameter  int unsigned WF    = FP_WF,
  localparam int unsigned IN_W  = 1 + WE + WF,
  localparam int unsigned OUT_W = 3 + WE + WF
) (
  input  logic                             clk,
  input  logic                             rst,
  fp_ieee_to_flopoco_enc_if.slave          in_if,
  fp_ieee_to_flopoco_enc_if.master         out_if
`ifdef FP_ENC_STATS_EN
  ,
  input  logic                             stat_clr,
  output logic [15:0]                      stat_flush,
  output logic [15:0]                      stat_nan
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] s1_data_q, s1_data_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_W-1:0] enc_c;
  logic             s2_load_c, s1_load_c, accept_c;

  fp_enc_classify #(.WE(WE), .WF(WF)) u_classify (
    .in_data_i (in_if.data),
    .enc_c_o   (enc_c)
  );

  // Stage advance; s1_data only captures on a real handshake so idle X never enters.
  always_comb begin
    s2_load_c   = !out_valid_q || out_if.ready;
    s1_load_c   = !s1_valid_q || s2_load_c;
    accept_c    = in_if.valid && s1_load_c;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s2_load_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = s1_data_q;
    end
    if (s1_load_c) s1_valid_d = accept_c;
    if (accept_c)  s1_data_d  = enc_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_data_q   <= '0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      s1_data_q   <= s1_data_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_if.ready  = s1_load_c;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;

`ifdef FP_ENC_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] nan_cnt_q, nan_cnt_d;
  logic        flush_c, nan_c;

  // Counters bump on stage-1 load; clear wins over increment, both saturate.
  always_comb begin
    flush_c     = (in_if.data[WF +: WE] == '0) && (in_if.data[WF-1:0] != '0);
    nan_c       = (enc_c[OUT_W-1 -: 2] == EXN_NAN);
    flush_cnt_d = flush_cnt_q;
    nan_cnt_d   = nan_cnt_q;
    if (stat_clr) begin
      flush_cnt_d = '0;
      nan_cnt_d   = '0;
    end else if (accept_c) begin
      if (flush_c && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
      if (nan_c && nan_cnt_q != 16'hFFFF)     nan_cnt_d   = nan_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      nan_cnt_q   <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      nan_cnt_q   <= nan_cnt_d;
    end
  end

  assign stat_flush = flush_cnt_q;
  assign stat_nan   = nan_cnt_q;
`endif

endmodule

// File: tb/tb_fp_ieee_to_flopoco_enc.sv
// Bench for fp_ieee_to_flopoco_enc: directed steps plus random valid/ready stream,
// expected words queued at input handshake and compared at output handshake.
module tb_fp_ieee_to_flopoco_enc;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   rnd    = 0;
  bit   sb_en  = 1;
  logic [30:0] exp_q[$];

  fp_ieee_to_flopoco_enc_if #(.DW(29)) in_if ();
  fp_ieee_to_flopoco_enc_if #(.DW(31)) out_if ();

`ifdef FP_ENC_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_flush;
  logic [15:0] stat_nan;
`endif

  fp_ieee_to_flopoco_enc dut (
    .clk    (clk),
    .rst    (rst),
    .in_if  (in_if.slave),
    .out_if (out_if.master)
`ifdef FP_ENC_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_flush (stat_flush),
    .stat_nan   (stat_nan)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [30:0] ref_enc(input logic [28:0] w);
    logic        s;
    logic [10:0] e;
    logic [16:0] f;
    s = w[28];
    e = w[27:17];
    f = w[16:0];
    if (e == 11'd0)        return {2'b00, s, 28'd0};
    else if (e == 11'h7FF) return {(f == 17'd0) ? 2'b10 : 2'b11, s, 28'd0};
    else                   return {2'b01, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd) out_if.ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Present one word, wait (bounded) for acceptance, queue its expected encoding.
  task automatic send(input logic [28:0] w, input logic [30:0] e);
    int n;
    n = 0;
    in_if.valid = 1'b1;
    in_if.data  = w;
    @(negedge clk);
    while (!in_if.ready && n < 2000) begin
      @(posedge clk); #1;
      if (rnd) out_if.ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(in_if.ready), 32'd1);
    if (in_if.ready) exp_q.push_back(e);
    @(posedge clk); #1;
    in_if.valid = 1'b0;
    in_if.data  = 'x;
    if (rnd) out_if.ready = ($urandom_range(0, 3) != 0);
  endtask

  // Output-side scoreboard and hold-stability monitor.
  logic [30:0] hold_q;
  bit          stall_q = 0;
  always @(negedge clk) begin
    if (rst && sb_en) begin
      if (stall_q) begin
        chk("hold_valid", 32'(out_if.valid), 32'd1);
        chk("hold_data", 32'(out_if.data), 32'(hold_q));
      end
      if (out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(out_if.data), 32'hFFFFFFFF);
        else chk("sb_data", 32'(out_if.data), 32'(exp_q.pop_front()));
      end
      stall_q = out_if.valid && !out_if.ready;
      hold_q  = out_if.data;
    end else begin
      stall_q = 0;
    end
  end

  initial begin
    logic [28:0] w;
    int          sel;
    rst          = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = 'x;
    out_if.ready = 1'b0;
`ifdef FP_ENC_STATS_EN
    stat_clr = 1'b0;
`endif
    #12;
    chk("rst_out_valid", 32'(out_if.valid), 32'd0);
    chk("rst_out_data", 32'(out_if.data), 32'd0);
    chk("rst_in_ready", 32'(in_if.ready), 32'd1);
`ifdef FP_ENC_STATS_EN
    chk("rst_stat_flush", 32'(stat_flush), 32'd0);
    chk("rst_stat_nan", 32'(stat_nan), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    out_if.ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_if.ready), 32'd1);
    @(posedge clk); #1;

    // Latency: presented in cycle n, visible in cycle n+2
    send(29'h07FE0000, 31'h27FE0000);
    @(negedge clk);
    chk("lat_not_early", 32'(out_if.valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid", 32'(out_if.valid), 32'd1);
    chk("lat_data", 32'(out_if.data), 32'h27FE0000);
    @(posedge clk); #1;

    // Specials
    send(29'h1FFE0000, 31'h50000000);
    send(29'h0FFE0001, 31'h60000000);
    send(29'h10000000, 31'h10000000);
    send(29'h00000005, 31'h00000000);
`ifdef FP_ENC_STATS_EN
    chk("stat_flush_one", 32'(stat_flush), 32'd1);
`endif
    idle(4);
    chk("specials_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure: two words buffered, third stalls, then all five drain
    out_if.ready = 1'b0;
    send(29'h07FE1234, ref_enc(29'h07FE1234));
    send(29'h18000001, ref_enc(29'h18000001));
    in_if.valid = 1'b1;
    in_if.data  = 29'h0FFE0000;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_if.ready), 32'd0);
      chk("bp_out_data", 32'(out_if.data), 32'(ref_enc(29'h07FE1234)));
      @(posedge clk); #1;
    end
    out_if.ready = 1'b1;
    send(29'h0FFE0000, ref_enc(29'h0FFE0000));
    send(29'h00012345, ref_enc(29'h00012345));
    send(29'h0ABCDEF0, ref_enc(29'h0ABCDEF0));
    idle(4);
    chk("bp_drain", 32'(exp_q.size()), 32'd0);

    // Random valid/ready stream
    rnd = 1;
    for (int i = 0; i < 10000; i++) begin
      w   = 29'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0)      w[27:17] = 11'd0;
      else if (sel == 1) w[27:17] = 11'h7FF;
      if ($urandom_range(0, 3) == 0) w[16:0] = 17'd0;
      send(w, ref_enc(w));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rnd = 0;
    out_if.ready = 1'b1;
    idle(6);
    chk("rand_drain", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with two words in flight
    out_if.ready = 1'b0;
    send(29'h07FE0001, ref_enc(29'h07FE0001));
    send(29'h07FE0002, ref_enc(29'h07FE0002));
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_if.valid), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_if.ready = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", 32'(in_if.ready), 32'd1);
    chk("rst2_no_stale", 32'(out_if.valid), 32'd0);
    @(posedge clk); #1;
    send(29'h08000000, 31'h28000000);
    @(negedge clk);
    chk("rst2_not_early", 32'(out_if.valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_lat_valid", 32'(out_if.valid), 32'd1);
    chk("rst2_lat_data", 32'(out_if.data), 32'h28000000);
    @(posedge clk); #1;
    idle(3);
    chk("rst2_drain", 32'(exp_q.size()), 32'd0);

`ifdef FP_ENC_STATS_EN
    // Saturation of the NaN counter, then synchronous clear
    sb_en = 0;
    in_if.valid = 1'b1;
    in_if.data  = 29'h0FFE0001;
    repeat (70000) @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.data  = 'x;
    idle(3);
    chk("stat_nan_sat", 32'(stat_nan), 32'h0000FFFF);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("stat_clr_nan", 32'(stat_nan), 32'd0);
    chk("stat_clr_flush", 32'(stat_flush), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
